// File: rtl/lights_out_engine_pkg.sv
// Shared types and helpers for the Lights-Out engine and its neighbours.
//   lo_state_t      : game FSM states
//   LFSR_TAPS       : feedback taps of the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
//   neighbour_mask  : cells toggled by one press of cell idx on an n-cell row/ring
package lights_pkg;

  typedef enum logic [1:0] {FREE, SCRAMBLE, PLAY, SOLVED} lo_state_t;

  localparam int unsigned MAX_CELLS = 64;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Result is MAX_CELLS wide; callers cast it down to their own row width.
  function automatic logic [MAX_CELLS-1:0] neighbour_mask(input int unsigned idx,
                                                          input int unsigned n,
                                                          input bit          wrap);
    logic [MAX_CELLS-1:0] one;
    logic [MAX_CELLS-1:0] m;
    one    = '0;
    one[0] = 1'b1;
    m      = one << idx;
    if (idx > 0)         m = m | (one << (idx - 1));
    else if (wrap)       m = m | (one << (n - 1));
    if (idx + 1 < n)     m = m | (one << (idx + 1));
    else if (wrap)       m = m | one;
    return m;
  endfunction

endpackage

// File: rtl/lights_out_engine_if.sv
// Board-side bundle of the Lights-Out engine.
//   sw       : raw switch levels (master -> slave)
//   new_game : 1-cycle start-scramble pulse (master -> slave)
//   lights   : LED pattern, moves: saturating move count,
//   solved   : board cleared in play, busy: scramble in progress (slave -> master)
interface lights_out_engine_if #(
  parameter int unsigned N_CELLS = 10,
  parameter int unsigned MOVE_W  = 8
);
  logic [N_CELLS-1:0] sw;
  logic               new_game;
  logic [N_CELLS-1:0] lights;
  logic [MOVE_W-1:0]  moves;
  logic               solved;
  logic               busy;

  modport master (output sw, output new_game,
                  input  lights, input moves, input solved, input busy);
  modport slave  (input  sw, input new_game,
                  output lights, output moves, output solved, output busy);
endinterface

// File: rtl/lights_out_engine_sw_edge_sync.sv
// Two-flop synchroniser per bit followed by an any-edge detector.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_async      : asynchronous input levels
//   o_pulse      : one-cycle pulse per bit for every rising or falling edge
// Reset loads the whole history with the current level so no edge fires on exit.
module sw_edge_sync #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_pulse
);
  logic [W-1:0] r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= i_async;
      r_s2 <= i_async;
      r_s3 <= i_async;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_pulse = r_s2 ^ r_s3;
endmodule

// File: rtl/lights_out_engine.sv
// Lights-Out game core: synchronised switch presses toggle a cell and its
// neighbours; an LFSR-driven scramble builds always-solvable puzzles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of lights_out_engine_if (sw/new_game in,
//              lights/moves/solved/busy out)
module lights_out_engine import lights_pkg::*; #(
  parameter int unsigned N_CELLS   = 10,
  parameter int unsigned WRAP      = 0,
  parameter int unsigned MOVE_W    = 8,
  parameter int unsigned SCR_STEPS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  lights_out_engine_if.slave  bus
);
  localparam int unsigned IDX_W  = $clog2(N_CELLS);
  localparam int unsigned CNT_W  = $clog2(N_CELLS + 1);
  localparam int unsigned SUM_W  = MOVE_W + CNT_W;
  localparam int unsigned STEP_W = $clog2(SCR_STEPS + 1);
  localparam logic [MOVE_W-1:0] MOVES_MAX = '1;

  lo_state_t          r_state;
  logic [N_CELLS-1:0] r_lights;
  logic [MOVE_W-1:0]  r_moves;
  logic [15:0]        r_lfsr;
  logic [STEP_W-1:0]  r_step;

  logic [N_CELLS-1:0] w_press, w_toggle, w_play_lights, w_scr_mask, w_scr_lights;
  logic [CNT_W-1:0]   w_pop;
  logic [SUM_W-1:0]   w_sum;
  logic [MOVE_W-1:0]  w_moves_sat;
  logic [IDX_W-1:0]   w_idx;
  logic               w_scr_done, w_start;

  sw_edge_sync #(.W(N_CELLS)) u_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (bus.sw),
    .o_pulse (w_press)
  );

  // XOR of all pressed masks is order-independent, so simultaneous presses
  // collapse into one toggle vector.
  always_comb begin
    w_toggle = '0;
    w_pop    = '0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (w_press[i]) begin
        w_toggle = w_toggle ^ N_CELLS'(neighbour_mask(i, N_CELLS, WRAP != 0));
        w_pop    = w_pop + CNT_W'(1);
      end
    end
  end

  assign w_play_lights = r_lights ^ w_toggle;
  assign w_sum         = SUM_W'(r_moves) + SUM_W'(w_pop);
  assign w_moves_sat   = (w_sum > SUM_W'(MOVES_MAX)) ? MOVES_MAX : w_sum[MOVE_W-1:0];

  assign w_idx        = IDX_W'(r_lfsr % 16'(N_CELLS));
  assign w_scr_mask   = N_CELLS'(neighbour_mask(32'(w_idx), N_CELLS, WRAP != 0));
  assign w_scr_lights = r_lights ^ w_scr_mask;
  // Keep pressing past SCR_STEPS until the puzzle is non-trivial.
  assign w_scr_done   = (r_step >= STEP_W'(SCR_STEPS - 1)) && (w_scr_lights != '0);

  // new_game outranks any press landing in the same cycle.
  assign w_start = bus.new_game && (r_state != SCRAMBLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FREE;
      r_lights <= '0;
      r_moves  <= '0;
      r_lfsr   <= LFSR_SEED;
      r_step   <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
      if (w_start) begin
        r_state  <= SCRAMBLE;
        r_lights <= '0;
        r_moves  <= '0;
        r_step   <= '0;
      end else begin
        case (r_state)
          FREE: r_lights <= w_play_lights;
          SCRAMBLE: begin
            r_lights <= w_scr_lights;
            if (w_scr_done) begin
              r_state <= PLAY;
              r_moves <= '0;
            end else if (r_step < STEP_W'(SCR_STEPS - 1)) begin
              r_step <= r_step + 1'b1;
            end
          end
          PLAY: begin
            r_lights <= w_play_lights;
            r_moves  <= w_moves_sat;
            if (w_play_lights == '0) r_state <= SOLVED;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.lights = r_lights;
  assign bus.moves  = r_moves;
  assign bus.solved = (r_state == SOLVED);
  assign bus.busy   = (r_state == SCRAMBLE);
endmodule

// File: tb/tb_lights_out_engine.sv
// Bench for lights_out_engine: three instances (linear, ring, 2-bit move counter)
// share clock, reset and switches; a behavioural model tracks all of them.
module tb_lights_out_engine;
  localparam int unsigned N    = 10;
  localparam int unsigned SCR  = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int M_FREE = 0, M_SCR = 1, M_PLAY = 2, M_SOLVED = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw;
  logic         ng;
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           chk_on  = 1'b0;

  always #5 clk = ~clk;

  lights_out_engine_if #(.N_CELLS(N), .MOVE_W(8)) if_lin  ();
  lights_out_engine_if #(.N_CELLS(N), .MOVE_W(8)) if_wrap ();
  lights_out_engine_if #(.N_CELLS(N), .MOVE_W(2)) if_sat  ();

  assign if_lin.sw  = sw;  assign if_lin.new_game  = ng;
  assign if_wrap.sw = sw;  assign if_wrap.new_game = 1'b0;
  assign if_sat.sw  = sw;  assign if_sat.new_game  = ng;

  lights_out_engine #(.N_CELLS(N), .WRAP(0), .MOVE_W(8), .SCR_STEPS(SCR), .LFSR_SEED(SEED))
    u_lin  (.clk(clk), .rst(rst), .bus(if_lin));
  lights_out_engine #(.N_CELLS(N), .WRAP(1), .MOVE_W(8), .SCR_STEPS(SCR), .LFSR_SEED(SEED))
    u_wrap (.clk(clk), .rst(rst), .bus(if_wrap));
  lights_out_engine #(.N_CELLS(N), .WRAP(0), .MOVE_W(2), .SCR_STEPS(SCR), .LFSR_SEED(SEED))
    u_sat  (.clk(clk), .rst(rst), .bus(if_sat));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cells within distance 1 of i; on a ring, 0 and N-1 are also adjacent.
  function automatic logic [N-1:0] cell_mask(input int i, input bit wrap);
    logic [N-1:0] m;
    m = '0;
    for (int j = 0; j < N; j++) begin
      int d;
      d = (i > j) ? i - j : j - i;
      if (d <= 1 || (wrap && d == N - 1)) m[j] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [N-1:0] press_mask(input logic [N-1:0] p, input bit wrap);
    logic [N-1:0] m;
    m = '0;
    for (int j = 0; j < N; j++) if (p[j]) m = m ^ cell_mask(j, wrap);
    return m;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // ---------------- reference model ----------------
  // A switch change seen at posedge k is applied to the lights at posedge k+2.
  int           m_state;
  int           m_moves = 0;
  int           m_steps;
  int           m_idx;
  int           m_log[$];
  logic [15:0]  m_lfsr;
  logic [N-1:0] m_lights, m_wlights, m_prev, m_d1, m_d2;
  logic [N-1:0] m_scr_next, m_play_next;

  always_comb begin
    m_idx       = int'(m_lfsr) % N;
    m_scr_next  = m_lights ^ cell_mask(m_idx, 1'b0);
    m_play_next = m_lights ^ press_mask(m_d2, 1'b0);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_state <= M_FREE; m_lights <= '0; m_wlights <= '0; m_moves <= 0;
      m_steps <= 0; m_lfsr <= SEED; m_prev <= sw; m_d1 <= '0; m_d2 <= '0;
      m_log.delete();
    end else begin
      m_d2     <= m_d1;
      m_d1     <= sw ^ m_prev;
      m_prev   <= sw;
      m_lfsr   <= lfsr_next(m_lfsr);
      m_wlights <= m_wlights ^ press_mask(m_d2, 1'b1);
      if (ng && m_state != M_SCR) begin
        m_state <= M_SCR; m_lights <= '0; m_moves <= 0; m_steps <= 0;
        m_log.delete();
      end else if (m_state == M_FREE) begin
        m_lights <= m_play_next;
      end else if (m_state == M_SCR) begin
        m_lights <= m_scr_next;
        m_log.push_back(m_idx);
        m_steps <= m_steps + 1;
        if (m_steps + 1 >= SCR && m_scr_next != '0) begin
          m_state <= M_PLAY; m_moves <= 0;
        end
      end else if (m_state == M_PLAY) begin
        m_lights <= m_play_next;
        m_moves  <= m_moves + $countones(m_d2);
        if (m_play_next == '0) m_state <= M_SOLVED;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("lin.lights", 32'(if_lin.lights), 32'(m_lights));
      check("lin.moves",  32'(if_lin.moves),  32'((m_moves > 255) ? 255 : m_moves));
      check("lin.solved", 32'(if_lin.solved), 32'(m_state == M_SOLVED));
      check("lin.busy",   32'(if_lin.busy),   32'(m_state == M_SCR));
      check("wrap.lights", 32'(if_wrap.lights), 32'(m_wlights));
      check("sat.lights", 32'(if_sat.lights), 32'(m_lights));
      check("sat.moves",  32'(if_sat.moves),  32'((m_moves > 3) ? 3 : m_moves));
    end
  end

  // ---------------- directed + random stimulus ----------------
  typedef struct { logic [N-1:0] tgl; logic [N-1:0] exp_lin; logic [N-1:0] exp_wrap; } vec_t;
  vec_t         vecs[12];
  logic [N-1:0] par, acc, first;
  int           cyc, mv_exp, c;

  task automatic start_game(output int cycles);
    cycles = 0;
    ng = 1'b1; tick(1); ng = 1'b0;
    check("ng.busy_next", 32'(if_lin.busy), 32'd1);
    while (if_lin.busy && cycles < 200) begin
      cycles++;
      tick(1);
    end
    check("scr.timeout", 32'(if_lin.busy), 32'd0);
  endtask

  initial begin
    sw = N'($urandom);
    ng = 1'b0;
    rst = 1'b1;
    tick(2);
    chk_on = 1'b1;
    check("rst.lights", 32'(if_lin.lights), 32'd0);
    check("rst.moves",  32'(if_lin.moves),  32'd0);
    check("rst.busy",   32'(if_lin.busy),   32'd0);
    check("rst.solved", 32'(if_lin.solved), 32'd0);
    rst = 1'b0;
    tick(4);
    check("rst.no_press", 32'(if_lin.lights), 32'd0);

    // press-to-lights latency
    sw[9] = ~sw[9];
    tick(2);
    check("lat.2clk", 32'(if_lin.lights), 32'd0);
    tick(1);
    check("lat.3clk", 32'(if_lin.lights), 32'(10'b1100000000));
    sw[9] = ~sw[9];
    tick(3);

    // FREE-mode toggle table, cumulative from all-dark
    vecs[0]  = '{10'b1000000000, 10'b1100000000, 10'b1100000001};
    vecs[1]  = '{10'b1000000000, 10'b0000000000, 10'b0000000000};
    vecs[2]  = '{10'b0000010000, 10'b0000111000, 10'b0000111000};
    vecs[3]  = '{10'b0000010000, 10'b0000000000, 10'b0000000000};
    vecs[4]  = '{10'b0000000001, 10'b0000000011, 10'b1000000011};
    vecs[5]  = '{10'b0000000001, 10'b0000000000, 10'b0000000000};
    vecs[6]  = '{10'b0000001100, 10'b0000010010, 10'b0000010010};
    vecs[7]  = '{10'b0000001100, 10'b0000000000, 10'b0000000000};
    vecs[8]  = '{10'b0000011000, 10'b0000100100, 10'b0000100100};
    vecs[9]  = '{10'b0000011000, 10'b0000000000, 10'b0000000000};
    vecs[10] = '{10'b0100000010, 10'b1110000111, 10'b1110000111};
    vecs[11] = '{10'b1000000001, 10'b0010000100, 10'b1010000101};
    for (int i = 0; i < 12; i++) begin
      sw = sw ^ vecs[i].tgl;
      tick(3);
      check($sformatf("vec%0d.lin", i),  32'(if_lin.lights),  32'(vecs[i].exp_lin));
      check($sformatf("vec%0d.wrap", i), 32'(if_wrap.lights), 32'(vecs[i].exp_wrap));
    end

    // game 1: scramble, then solve by pressing every cell pressed an odd number of times
    start_game(cyc);
    check("scr.len_ge_steps", 32'(cyc >= SCR), 32'd1);
    check("scr.log_len", 32'(cyc), 32'(m_log.size()));
    par = '0; acc = '0;
    foreach (m_log[k]) begin
      par[m_log[k]] = ~par[m_log[k]];
      acc = acc ^ cell_mask(m_log[k], 1'b0);
    end
    check("scr.lights", 32'(if_lin.lights), 32'(acc));
    check("scr.nonzero", 32'(if_lin.lights != '0), 32'd1);
    check("scr.moves0", 32'(if_lin.moves), 32'd0);
    first = par & (~par + 1'b1);
    sw = sw ^ first;
    tick(1);
    sw = sw ^ (par & ~first);
    tick(3);
    mv_exp = $countones(par);
    check("solve.lights", 32'(if_lin.lights), 32'd0);
    check("solve.solved", 32'(if_lin.solved), 32'd1);
    check("solve.moves", 32'(if_lin.moves), 32'(mv_exp));

    // presses ignored while solved
    sw[5] = ~sw[5];
    tick(4);
    check("solved.lights_frozen", 32'(if_lin.lights), 32'd0);
    check("solved.moves_frozen", 32'(if_lin.moves), 32'(mv_exp));
    check("solved.stays", 32'(if_lin.solved), 32'd1);

    // game 2: simultaneous pair, then saturation of the 2-bit counter
    start_game(cyc);
    check("scr2.len_ge_steps", 32'(cyc >= SCR), 32'd1);
    sw = sw ^ 10'b0000011000;
    tick(3);
    check("play.pair_moves", 32'(if_lin.moves), 32'd2);
    if (m_state == M_PLAY) begin
      c = (m_lights == cell_mask(0, 1'b0)) ? 9 : 0;
      sw[c] = ~sw[c]; tick(1);
      sw[c] = ~sw[c]; tick(1);
      sw[c] = ~sw[c]; tick(3);
      check("sat.moves_11", 32'(if_sat.moves), 32'd3);
      check("lin.moves_5", 32'(if_lin.moves), 32'd5);
    end

    // reset in the middle of a scramble
    ng = 1'b1; tick(1); ng = 1'b0;
    tick(3);
    check("rst_scr.pre_busy", 32'(if_lin.busy), 32'd1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst_scr.lights", 32'(if_lin.lights), 32'd0);
    check("rst_scr.busy", 32'(if_lin.busy), 32'd0);
    check("rst_scr.moves", 32'(if_lin.moves), 32'd0);
    check("rst_scr.solved", 32'(if_lin.solved), 32'd0);

    // random phase against the model
    for (int k = 0; k < 800; k++) begin
      ng  = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) sw = sw ^ (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) sw = sw ^ N'($urandom);
      tick(1);
    end
    ng = 1'b0; rst = 1'b0;
    tick(4);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end
endmodule
